// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// Holds the transmit FSM state encoding, the parity_mode codes and the
// default frame geometry used by uart_xmit_cfg.
package uart_pkg;

   // Transmit FSM states
   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } xmitState_t;

   // Encoding of the parity_mode input
   typedef enum logic [1:0] {
      ParNone = 2'b00,
      ParEven = 2'b01,
      ParOdd  = 2'b10,
      ParMark = 2'b11
   } parityMode_t;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_OVS    = 16;

   // Parity bit for a frame given the mode and the XOR of all data bits
   function automatic logic parityBit(input parityMode_t mode, input logic dataXor);
      logic bitVal;
      case (mode)
         ParEven: bitVal = dataXor;
         ParOdd:  bitVal = ~dataXor;
         ParMark: bitVal = 1'b1;
         default: bitVal = 1'b0;
      endcase
      return bitVal;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO for uart_xmit_cfg. Power-of-two depth, pointers wrap
// naturally. A push while full is dropped even if a pop happens the same
// cycle, so full is judged on the registered level only.
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     uart_clk,
   input  logic                     sys_rst_l,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic             pushOk;
   logic             popOk;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign pushOk  = push && !full;
   assign popOk   = pop && !empty;
   assign popData = mem[rdPtr];

   // Storage write; contents need no reset since level gates every read
   always_ff @(posedge uart_clk) begin
      if (pushOk) begin
         mem[wrPtr] <= pushData;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge uart_clk or posedge sys_rst_l) begin
      if (sys_rst_l) begin
         wrPtr <= '0;
         rdPtr <= '0;
         level <= '0;
      end else begin
         if (pushOk) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (popOk) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({pushOk, popOk})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_xmit_cfg.sv
// Configurable UART transmitter: FIFO-buffered, DATA_W data bits LSB first,
// optional even/odd/mark parity, one or two stop bits, OVS clocks per bit.
// Frame settings are captured when a word is popped so that config changes
// never disturb a frame in flight.
// Optional macro UART_XMIT_BREAK_EN adds break_reqH: holds the line low and
// suppresses FIFO pops while the transmitter is idle or at a frame boundary.
module uart_xmit_cfg
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned OVS        = DEF_OVS,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          uart_clk,
   input  logic                          sys_rst_l,
   input  logic                          xmitH,
   input  logic [DATA_W-1:0]             xmit_dataH,
   input  logic [1:0]                    parity_mode,
   input  logic                          stop2H,
`ifdef UART_XMIT_BREAK_EN
   input  logic                          break_reqH,
`endif
   output logic                          uart_xmitH,
   output logic                          xmit_readyH,
   output logic                          xmit_busyH,
   output logic                          xmit_doneH,
   output logic                          xmit_ovfH,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned CW = $clog2(OVS);
   localparam int unsigned BW = $clog2(DATA_W);
   localparam logic [CW-1:0] CELL_LAST = CW'(OVS - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

   xmitState_t        state;
   logic [CW-1:0]     cellCnt;
   logic [BW-1:0]     bitCnt;
   logic [DATA_W-1:0] shiftReg;
   parityMode_t       parMode;
   logic              parBitQ;
   logic              stopTwo;
   logic              stopSecond;
   logic              haveWord;

   logic              fifoPop;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [DATA_W-1:0] fifoData;
   logic              cellEnd;
   logic              bitEnd;
   logic              frameEnd;
   logic              breakReq;
   parityMode_t       modeIn;
   logic              nextParBit;

`ifdef UART_XMIT_BREAK_EN
   assign breakReq = break_reqH;
`else
   assign breakReq = 1'b0;
`endif

   assign cellEnd    = (cellCnt == CELL_LAST);
   assign bitEnd     = (bitCnt == BIT_LAST);
   assign frameEnd   = (state == StStop) && cellEnd && (!stopTwo || stopSecond);
   assign modeIn     = parityMode_t'(parity_mode);
   assign nextParBit = parityBit(modeIn, ^fifoData);

   assign xmit_readyH = !fifoFull;
   assign xmit_busyH  = (state != StIdle);

   uart_tx_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .uart_clk  (uart_clk),
      .sys_rst_l (sys_rst_l),
      .push      (xmitH),
      .pushData  (xmit_dataH),
      .pop       (fifoPop),
      .popData   (fifoData),
      .full      (fifoFull),
      .empty     (fifoEmpty),
      .level     (fifo_level)
   );

   // Pop when idle with nothing staged, or at the last stop cycle so frames chain
   always_comb begin
      fifoPop = 1'b0;
      if (!breakReq && !fifoEmpty) begin
         if ((state == StIdle) && !haveWord) begin
            fifoPop = 1'b1;
         end
         if (frameEnd) begin
            fifoPop = 1'b1;
         end
      end
   end

   // Transmit FSM, bit-cell counters, shifter and registered line/pulses
   always_ff @(posedge uart_clk or posedge sys_rst_l) begin
      if (sys_rst_l) begin
         state      <= StIdle;
         cellCnt    <= '0;
         bitCnt     <= '0;
         shiftReg   <= '0;
         parMode    <= ParNone;
         parBitQ    <= 1'b0;
         stopTwo    <= 1'b0;
         stopSecond <= 1'b0;
         haveWord   <= 1'b0;
         uart_xmitH <= 1'b1;
         xmit_doneH <= 1'b0;
         xmit_ovfH  <= 1'b0;
      end else begin
         xmit_doneH <= 1'b0;
         // Overflow looks only at the pre-edge level: a same-cycle pop does not help
         xmit_ovfH  <= xmitH && fifoFull;
         if (state != StIdle) begin
            cellCnt <= cellEnd ? '0 : cellCnt + 1'b1;
         end
         case (state)
            StIdle: begin
               if (breakReq) begin
                  uart_xmitH <= 1'b0;
               end else if (haveWord) begin
                  haveWord   <= 1'b0;
                  state      <= StStart;
                  uart_xmitH <= 1'b0;
                  cellCnt    <= '0;
               end else begin
                  uart_xmitH <= 1'b1;
                  if (fifoPop) begin
                     haveWord <= 1'b1;
                     shiftReg <= fifoData;
                     parMode  <= modeIn;
                     parBitQ  <= nextParBit;
                     stopTwo  <= stop2H;
                  end
               end
            end
            StStart: begin
               if (cellEnd) begin
                  state      <= StData;
                  uart_xmitH <= shiftReg[0];
                  shiftReg   <= shiftReg >> 1;
                  bitCnt     <= '0;
               end
            end
            StData: begin
               if (cellEnd) begin
                  if (!bitEnd) begin
                     uart_xmitH <= shiftReg[0];
                     shiftReg   <= shiftReg >> 1;
                     bitCnt     <= bitCnt + 1'b1;
                  end else if (parMode != ParNone) begin
                     state      <= StParity;
                     uart_xmitH <= parBitQ;
                  end else begin
                     state      <= StStop;
                     uart_xmitH <= 1'b1;
                     stopSecond <= 1'b0;
                  end
               end
            end
            StParity: begin
               if (cellEnd) begin
                  state      <= StStop;
                  uart_xmitH <= 1'b1;
                  stopSecond <= 1'b0;
               end
            end
            StStop: begin
               if (cellEnd) begin
                  if (stopTwo && !stopSecond) begin
                     stopSecond <= 1'b1;
                  end else begin
                     xmit_doneH <= 1'b1;
                     if (fifoPop) begin
                        // Chain straight into the next start bit, no idle cell
                        state      <= StStart;
                        uart_xmitH <= 1'b0;
                        shiftReg   <= fifoData;
                        parMode    <= modeIn;
                        parBitQ    <= nextParBit;
                        stopTwo    <= stop2H;
                     end else begin
                        state      <= StIdle;
                        uart_xmitH <= !breakReq;
                     end
                  end
               end
            end
            default: begin
               state      <= StIdle;
               uart_xmitH <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_xmit_cfg.sv
// Directed bench for uart_xmit_cfg at default parameters (DATA_W=8, OVS=16,
// FIFO_DEPTH=4). Line and status outputs are sampled on the falling edge into
// arrays indexed by cycles after the first write edge, then checked per test.
module tb_uart_xmit_cfg;

   logic       uart_clk = 1'b0;
   logic       sys_rst_l = 1'b0;
   logic       xmitH = 1'b0;
   logic [7:0] xmit_dataH = 8'h00;
   logic [1:0] parity_mode = 2'b00;
   logic       stop2H = 1'b0;
`ifdef UART_XMIT_BREAK_EN
   logic       break_reqH = 1'b0;
`endif
   logic       uart_xmitH;
   logic       xmit_readyH;
   logic       xmit_busyH;
   logic       xmit_doneH;
   logic       xmit_ovfH;
   logic [2:0] fifo_level;

   int tests = 0;
   int failed = 0;

   logic       lineS  [0:1023];
   logic       doneS  [0:1023];
   logic       readyS [0:1023];
   logic       ovfS   [0:1023];
   logic       busyS  [0:1023];
   logic [2:0] lvlS   [0:1023];
   logic [7:0] wrQ    [0:7];
   int         brkOffAt = -1;

   always #5 uart_clk = ~uart_clk;

   uart_xmit_cfg dut (
      .uart_clk    (uart_clk),
      .sys_rst_l   (sys_rst_l),
      .xmitH       (xmitH),
      .xmit_dataH  (xmit_dataH),
      .parity_mode (parity_mode),
      .stop2H      (stop2H),
`ifdef UART_XMIT_BREAK_EN
      .break_reqH  (break_reqH),
`endif
      .uart_xmitH  (uart_xmitH),
      .xmit_readyH (xmit_readyH),
      .xmit_busyH  (xmit_busyH),
      .xmit_doneH  (xmit_doneH),
      .xmit_ovfH   (xmit_ovfH),
      .fifo_level  (fifo_level)
   );

   // Caller presents wrQ[0] before edge N; sample i is taken after edge N+i.
   task automatic capture(input int ncyc, input int nWr, input int chgAt,
                          input logic [1:0] newMode, input logic newStop);
      for (int i = 0; i < ncyc; i++) begin
         @(posedge uart_clk);
         #1;
         if (i + 1 < nWr) begin
            xmitH      = 1'b1;
            xmit_dataH = wrQ[i+1];
         end else begin
            xmitH = 1'b0;
         end
         if (i == chgAt) begin
            parity_mode = newMode;
            stop2H      = newStop;
         end
`ifdef UART_XMIT_BREAK_EN
         if (i == brkOffAt) break_reqH = 1'b0;
`endif
         @(negedge uart_clk);
         lineS[i]  = uart_xmitH;
         doneS[i]  = xmit_doneH;
         readyS[i] = xmit_readyH;
         ovfS[i]   = xmit_ovfH;
         busyS[i]  = xmit_busyH;
         lvlS[i]   = fifo_level;
      end
   endtask

   task automatic test_reset();
      #1 sys_rst_l = 1'b1;
      repeat (3) @(negedge uart_clk);
      tests++;
      if (uart_xmitH !== 1'b1) begin
         failed++; $display("FAIL reset_line got %b want 1", uart_xmitH);
      end
      tests++;
      if (xmit_readyH !== 1'b1) begin
         failed++; $display("FAIL reset_ready got %b want 1", xmit_readyH);
      end
      tests++;
      if (xmit_busyH !== 1'b0) begin
         failed++; $display("FAIL reset_busy got %b want 0", xmit_busyH);
      end
      tests++;
      if ({xmit_doneH, xmit_ovfH} !== 2'b00) begin
         failed++; $display("FAIL reset_pulses got %b%b want 00", xmit_doneH, xmit_ovfH);
      end
      tests++;
      if (fifo_level !== 3'd0) begin
         failed++; $display("FAIL reset_level got %0d want 0", fifo_level);
      end
      sys_rst_l = 1'b0;
      repeat (2) @(negedge uart_clk);
   endtask

   // 0xA5, even parity, mid-frame config change must not matter
   task automatic test_parity_even();
      logic [10:0] expv;
      int dones;
      logic bad;
      expv = 11'b10101001010;
      parity_mode = 2'b01; stop2H = 1'b0;
      wrQ[0] = 8'hA5; xmitH = 1'b1; xmit_dataH = 8'hA5;
      capture(200, 1, 30, 2'b00, 1'b1);
      tests++;
      if (lineS[1] !== 1'b1) begin
         failed++; $display("FAIL even_pre_start got %b want 1", lineS[1]);
      end
      for (int j = 0; j < 11; j++) begin
         bad = 1'b0;
         for (int k = 0; k < 16; k++) if (lineS[2 + 16*j + k] !== expv[j]) bad = 1'b1;
         tests++;
         if (bad) begin
            failed++; $display("FAIL even_cell%0d got %b@mid want %b", j, lineS[10 + 16*j], expv[j]);
         end
      end
      dones = 0;
      for (int i = 0; i < 200; i++) if (doneS[i] === 1'b1) dones++;
      tests++;
      if (dones != 1 || doneS[178] !== 1'b1) begin
         failed++; $display("FAIL even_done got count %0d at178=%b want 1,1", dones, doneS[178]);
      end
      tests++;
      if (busyS[2] !== 1'b1 || busyS[190] !== 1'b0) begin
         failed++; $display("FAIL even_busy got %b%b want 10", busyS[2], busyS[190]);
      end
      tests++;
      if (lineS[178] !== 1'b1 || lineS[199] !== 1'b1) begin
         failed++; $display("FAIL even_idle_after got %b%b want 11", lineS[178], lineS[199]);
      end
   endtask

   task automatic test_parity_odd();
      logic [10:0] expv;
      logic bad;
      expv = 11'b11101001010;
      parity_mode = 2'b10; stop2H = 1'b0;
      wrQ[0] = 8'hA5; xmitH = 1'b1; xmit_dataH = 8'hA5;
      capture(190, 1, -1, 2'b00, 1'b0);
      for (int j = 0; j < 11; j++) begin
         bad = 1'b0;
         for (int k = 0; k < 16; k++) if (lineS[2 + 16*j + k] !== expv[j]) bad = 1'b1;
         tests++;
         if (bad) begin
            failed++; $display("FAIL odd_cell%0d got %b@mid want %b", j, lineS[10 + 16*j], expv[j]);
         end
      end
      tests++;
      if (doneS[178] !== 1'b1 || doneS[177] !== 1'b0) begin
         failed++; $display("FAIL odd_done got %b%b want 01", doneS[177], doneS[178]);
      end
   endtask

   task automatic test_no_parity();
      logic [9:0] expv;
      logic bad;
      int dones;
      expv = 10'b1101001010;
      parity_mode = 2'b00; stop2H = 1'b0;
      wrQ[0] = 8'hA5; xmitH = 1'b1; xmit_dataH = 8'hA5;
      capture(180, 1, -1, 2'b00, 1'b0);
      for (int j = 0; j < 10; j++) begin
         bad = 1'b0;
         for (int k = 0; k < 16; k++) if (lineS[2 + 16*j + k] !== expv[j]) bad = 1'b1;
         tests++;
         if (bad) begin
            failed++; $display("FAIL nopar_cell%0d got %b@mid want %b", j, lineS[10 + 16*j], expv[j]);
         end
      end
      dones = 0;
      for (int i = 0; i < 180; i++) if (doneS[i] === 1'b1) dones++;
      tests++;
      if (dones != 1 || doneS[162] !== 1'b1) begin
         failed++; $display("FAIL nopar_done got count %0d at162=%b want 1,1", dones, doneS[162]);
      end
   endtask

   // Two stop bits, 0x00 then 0xFF written on consecutive cycles
   task automatic test_back_to_back();
      logic [21:0] expv;
      logic bad;
      int dones;
      expv = 22'b1111111111011000000000;
      parity_mode = 2'b00; stop2H = 1'b1;
      wrQ[0] = 8'h00; wrQ[1] = 8'hFF; xmitH = 1'b1; xmit_dataH = 8'h00;
      capture(370, 2, -1, 2'b00, 1'b1);
      for (int j = 0; j < 22; j++) begin
         bad = 1'b0;
         for (int k = 0; k < 16; k++) if (lineS[2 + 16*j + k] !== expv[j]) bad = 1'b1;
         tests++;
         if (bad) begin
            failed++; $display("FAIL b2b_cell%0d got %b@mid want %b", j, lineS[10 + 16*j], expv[j]);
         end
      end
      dones = 0;
      for (int i = 0; i < 370; i++) if (doneS[i] === 1'b1) dones++;
      tests++;
      if (dones != 2 || doneS[178] !== 1'b1 || doneS[354] !== 1'b1) begin
         failed++;
         $display("FAIL b2b_done got count %0d d178=%b d354=%b want 2,1,1",
                  dones, doneS[178], doneS[354]);
      end
      stop2H = 1'b0;
   endtask

   // Six writes on six consecutive cycles into an idle transmitter
   task automatic test_overflow();
      logic [2:0] expLvl [0:5];
      logic [7:0] got;
      int ovfs;
      int dones;
      expLvl[0] = 3'd1; expLvl[1] = 3'd1; expLvl[2] = 3'd2;
      expLvl[3] = 3'd3; expLvl[4] = 3'd4; expLvl[5] = 3'd4;
      parity_mode = 2'b00; stop2H = 1'b0;
      for (int w = 0; w < 6; w++) wrQ[w] = 8'(w + 1);
      xmitH = 1'b1; xmit_dataH = wrQ[0];
      capture(830, 6, -1, 2'b00, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (lvlS[i] !== expLvl[i]) begin
            failed++; $display("FAIL ovf_level%0d got %0d want %0d", i, lvlS[i], expLvl[i]);
         end
      end
      ovfs = 0;
      for (int i = 0; i < 830; i++) if (ovfS[i] === 1'b1) ovfs++;
      tests++;
      if (ovfs != 1 || ovfS[5] !== 1'b1) begin
         failed++; $display("FAIL ovf_pulse got count %0d at5=%b want 1,1", ovfs, ovfS[5]);
      end
      tests++;
      if (readyS[3] !== 1'b1 || readyS[4] !== 1'b0 || readyS[161] !== 1'b0) begin
         failed++;
         $display("FAIL ovf_ready_low got %b%b%b want 100", readyS[3], readyS[4], readyS[161]);
      end
      tests++;
      if (readyS[162] !== 1'b1 || lvlS[162] !== 3'd3) begin
         failed++; $display("FAIL ovf_next_pop got rdy %b lvl %0d want 1,3", readyS[162], lvlS[162]);
      end
      for (int f = 0; f < 5; f++) begin
         for (int b = 0; b < 8; b++) got[b] = lineS[2 + 160*f + 16*(1 + b) + 8];
         tests++;
         if (got !== 8'(f + 1)) begin
            failed++; $display("FAIL ovf_frame%0d got %02h want %02h", f, got, 8'(f + 1));
         end
      end
      dones = 0;
      for (int i = 0; i < 830; i++) if (doneS[i] === 1'b1) dones++;
      tests++;
      if (dones != 5 || doneS[802] !== 1'b1 || lvlS[829] !== 3'd0) begin
         failed++;
         $display("FAIL ovf_drain got dones %0d d802=%b lvl %0d want 5,1,0",
                  dones, doneS[802], lvlS[829]);
      end
   endtask

   // Reset at frame cycle 50 with one more word still queued
   task automatic test_reset_midframe();
      int dones;
      logic bad;
      parity_mode = 2'b00; stop2H = 1'b0;
      wrQ[0] = 8'h00; wrQ[1] = 8'h00; xmitH = 1'b1; xmit_dataH = 8'h00;
      capture(52, 2, -1, 2'b00, 1'b0);
      tests++;
      if (lineS[51] !== 1'b0 || lvlS[51] !== 3'd1) begin
         failed++; $display("FAIL rstmid_before got line %b lvl %0d want 0,1", lineS[51], lvlS[51]);
      end
      sys_rst_l = 1'b1;
      #1;
      tests++;
      if (uart_xmitH !== 1'b1 || fifo_level !== 3'd0 || xmit_busyH !== 1'b0) begin
         failed++;
         $display("FAIL rstmid_async got line %b lvl %0d busy %b want 1,0,0",
                  uart_xmitH, fifo_level, xmit_busyH);
      end
      @(posedge uart_clk);
      #1 sys_rst_l = 1'b0;
      capture(300, 0, -1, 2'b00, 1'b0);
      dones = 0;
      bad = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (doneS[i] === 1'b1) dones++;
         if (lineS[i] !== 1'b1) bad = 1'b1;
      end
      tests++;
      if (dones != 0 || bad) begin
         failed++; $display("FAIL rstmid_after got dones %0d line_dropped %b want 0,0", dones, bad);
      end
   endtask

`ifdef UART_XMIT_BREAK_EN
   // Break held 300 cycles with 0x55 queued, then the frame goes out
   task automatic test_break();
      logic [9:0] expv;
      logic bad;
      expv = 10'b1010101010;
      parity_mode = 2'b00; stop2H = 1'b0;
      break_reqH = 1'b1; brkOffAt = 299;
      wrQ[0] = 8'h55; xmitH = 1'b1; xmit_dataH = 8'h55;
      capture(470, 1, -1, 2'b00, 1'b0);
      brkOffAt = -1;
      bad = 1'b0;
      for (int i = 0; i < 300; i++) if (lineS[i] !== 1'b0) bad = 1'b1;
      tests++;
      if (bad || lineS[300] !== 1'b1) begin
         failed++; $display("FAIL brk_low got dropped %b end %b want 0,1", bad, lineS[300]);
      end
      tests++;
      if (lvlS[299] !== 3'd1) begin
         failed++; $display("FAIL brk_hold got lvl %0d want 1", lvlS[299]);
      end
      for (int j = 0; j < 10; j++) begin
         bad = 1'b0;
         for (int k = 0; k < 16; k++) if (lineS[301 + 16*j + k] !== expv[j]) bad = 1'b1;
         tests++;
         if (bad) begin
            failed++; $display("FAIL brk_cell%0d got %b@mid want %b", j, lineS[309 + 16*j], expv[j]);
         end
      end
      tests++;
      if (doneS[461] !== 1'b1) begin
         failed++; $display("FAIL brk_done got %b want 1", doneS[461]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_parity_even();
      test_parity_odd();
      test_no_parity();
      test_back_to_back();
      test_overflow();
      test_reset_midframe();
`ifdef UART_XMIT_BREAK_EN
      test_break();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/uart_xmit_cfg.md
UART_XMIT_CFG -- requirements
Module: uart_xmit_cfg

Interface
REQ-001 Parameter DATA_W, 8, data bits per frame (legal 5..9).
REQ-002 Parameter OVS, 16, uart_clk cycles per bit cell (legal 4..64).
REQ-003 Parameter FIFO_DEPTH, 4, transmit FIFO entries (power of 2, 2..16).
REQ-004 Port uart_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port sys_rst_l  in  1  asynchronous, active-high reset.
REQ-006 Port xmitH  in  1  write strobe; pushes xmit_dataH into the FIFO.
REQ-007 Port xmit_dataH  in  DATA_W  word to transmit, LSB first.
REQ-008 Port parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit always 1).
REQ-009 Port stop2H  in  1  0 = one stop bit, 1 = two stop bits.
REQ-010 Port uart_xmitH  out  1  registered serial line, idle high.
REQ-011 Port xmit_readyH  out  1  FIFO not full.
REQ-012 Port xmit_busyH  out  1  state is not IDLE.
REQ-013 Port xmit_doneH  out  1  one-cycle pulse per completed frame.
REQ-014 Port xmit_ovfH  out  1  one-cycle pulse when a write is dropped.
REQ-015 Port fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; each START/DATA/PARITY/STOP bit cell lasts exactly OVS cycles.
REQ-017 IDLE with FIFO non-empty SHALL pop one word and latch it, parity_mode and stop2H; the next edge enters START with uart_xmitH=0.
REQ-018 A write to an empty FIFO in IDLE at edge N SHALL drive uart_xmitH low from edge N+2.
REQ-019 DATA SHALL emit DATA_W bits LSB first, then go to PARITY when latched mode != 00, else STOP.
REQ-020 Parity bit SHALL be XOR of data (even), its inverse (odd), or 1 (mark).
REQ-021 STOP SHALL drive high for OVS or 2*OVS cycles per latched stop2H.
REQ-022 At STOP end, xmit_doneH SHALL pulse the next cycle; FIFO non-empty goes directly to START (no idle cell), else IDLE.
REQ-023 Changes to parity_mode/stop2H mid-frame SHALL NOT affect the frame in progress.
REQ-024 A write while fifo_level==FIFO_DEPTH SHALL be dropped and pulse xmit_ovfH, even if a pop occurs that cycle.
REQ-025 Simultaneous accepted push and pop SHALL leave fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 Reset SHALL force IDLE, FIFO empty, fifo_level=0, uart_xmitH=1, xmit_readyH=1, xmit_busyH=0, xmit_doneH=0, xmit_ovfH=0, counters 0.
REQ-027 Reset mid-frame SHALL abort the frame, discard FIFO contents and return the line high immediately.

Configuration
REQ-028 Macro UART_XMIT_BREAK_EN SHALL add input break_reqH; while high in IDLE or at frame end, line held low and FIFO pops suppressed; FIFO writes still accepted.
REQ-029 Without UART_XMIT_BREAK_EN the port SHALL be absent and break behaviour SHALL not exist.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum, parity_mode codes and default DATA_W/OVS constants.
REQ-031 The FIFO SHALL be sub-module uart_tx_fifo (push, pop, full, empty, level); uart_xmit_cfg holds FSM, bit/cell counters and shifter.

Verification
REQ-032 DATA_W=8, OVS=16, mode 01, stop2H=0, write 0xA5 -> 176-cycle frame 0,1,0,1,0,0,1,0,1,0(parity),1; xmit_doneH pulses once.
REQ-033 Same with mode 10 -> parity bit 1; mode 00 -> 160-cycle frame, no parity cell.
REQ-034 stop2H=1, write 0x00 then 0xFF back-to-back -> second start bit immediately after 32 high cycles; two xmit_doneH pulses.
REQ-035 FIFO_DEPTH=4, 6 writes in 6 consecutive cycles in IDLE -> 5 accepted (1 popped, 4 queued), one xmit_ovfH pulse, xmit_readyH=0 until next pop.
REQ-036 Assert sys_rst_l at cycle 50 of a frame -> uart_xmitH=1 and fifo_level=0 same cycle, no xmit_doneH.
REQ-037 With UART_XMIT_BREAK_EN, break_reqH high for 300 cycles with 0x55 queued -> line low 300 cycles, then 0x55 frame starts.
